puf_window_timer: RTL and testbench
===================================

PUF_WINDOW_TIMER -- requirements
Module: puf_window_timer

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of independent timer channels.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the window and gap counters.
REQ-003 The block SHALL have parameter WCNT_W, default 8, giving the width of the per-channel window tally.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port en, input, N_CH bits: per-channel level enable.
REQ-007 The block SHALL have port target, input, N_CH*CNT_W bits: per-channel window length in cycles.
REQ-008 The block SHALL have port gap, input, N_CH*CNT_W bits: per-channel low time between periodic windows.
REQ-009 The block SHALL have port mode, input, N_CH bits: 0 selects one-shot, 1 selects periodic.
REQ-010 The block SHALL have port ctrl, output, N_CH bits: the registered window output that drives the PUF excitation.
REQ-011 The block SHALL have port done, output, N_CH bits: a one-cycle pulse at the end of each completed window.
REQ-012 The block SHALL have port err, output, N_CH bits: a one-cycle pulse when a channel starts with target equal to 0.
REQ-013 The block SHALL have port busy, output, N_CH bits: high while the channel is in RUN or GAP.
REQ-014 The block SHALL have port win_cnt, output, N_CH*WCNT_W bits: the number of completed windows since the channel started.

Function
REQ-015 Channels SHALL be fully independent; each has its own FSM with states IDLE, RUN, GAP and HOLD.
REQ-016 Each channel SHALL register en into en_d; a start is the edge where en=1 and en_d=0.
REQ-017 On start, target, gap and mode SHALL be latched into channel registers; later input changes have no effect until the next start.
REQ-018 On start with latched target>0: next state RUN, cnt<=1, ctrl<=1, win_cnt<=0.
REQ-019 On start with target=0: next state HOLD, ctrl stays 0, err pulses for exactly one cycle.
REQ-020 In RUN, if cnt<target then cnt<=cnt+1 and ctrl stays 1, so ctrl is high for exactly target consecutive cycles.
REQ-021 In RUN, when cnt=target: ctrl<=0, done pulses one cycle, win_cnt increments; next state is GAP if mode=1, otherwise HOLD.
REQ-022 win_cnt SHALL saturate at 2^WCNT_W-1 and never wrap.
REQ-023 GAP SHALL hold ctrl=0 for max(gap,1) cycles, then enter RUN with cnt<=1 and ctrl<=1.
REQ-024 HOLD SHALL keep ctrl=0 until en falls; no restart occurs while en stays high.
REQ-025 en=0 in any state SHALL force IDLE at the next edge with ctrl=0 and cnt=0; no done pulse; win_cnt is held.
REQ-026 A window cut short by en falling SHALL NOT be counted and SHALL NOT produce done.
REQ-027 Counters SHALL never wrap, because target and gap are at most 2^CNT_W-1 and cnt stops at target.
REQ-028 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-029 While rst=1, every channel SHALL be in IDLE with ctrl=0, done=0, err=0, busy=0, win_cnt=0, cnt=0, en_d=0 and all latched configuration registers =0.
REQ-030 Reset assertion mid-window SHALL drop ctrl asynchronously; after release, a start requires a fresh rising edge of en, relative to en_d=0.

Structure
REQ-031 A shared package puf_timer_pkg SHALL hold the FSM state enum and the mode encodings MODE_ONESHOT=0 and MODE_PERIODIC=1.
REQ-032 The per-channel logic SHALL be one sub-module, puf_window_chan, instantiated N_CH times by a generate loop in the top level.

Verification
REQ-033 Channel 0: target=50, mode=0, en held high -> ctrl high exactly 50 cycles starting 1 cycle after the en edge, one done pulse, win_cnt=1, busy low afterwards.
REQ-034 target=3, gap=2, mode=1, en high 20 cycles -> ctrl pattern 111001110011100..., a done pulse after each window, win_cnt increments per window.
REQ-035 target=0 -> err pulses once, ctrl stays 0, no done; gap=0 in periodic mode -> exactly 1 low cycle between windows.
REQ-036 en dropped at cycle 10 of a 50-cycle window -> ctrl=0 on the next edge, no done, win_cnt unchanged; en re-raised -> new full 50-cycle window.
REQ-037 rst pulsed mid-window -> ctrl=0 immediately; after release with en still high -> no restart until en toggles low then high.
REQ-038 All four channels started on staggered cycles with different targets -> each channel's ctrl timing is independent of the others; WCNT_W=2 saturation is checked at win_cnt=3.

Source files
------------

// File: rtl/puf_timer_pkg.sv
// Shared types for the PUF window timer: per-channel FSM states and mode encodings.
package puf_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_HOLD = 2'd3
  } chan_state_e;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/puf_window_chan.sv
// One PUF excitation window channel: latches its configuration on an en rising
// edge, then drives ctrl for target cycles, once or periodically with a gap.
module puf_window_chan
  import puf_timer_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned WCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  target,
  input  logic [CNT_W-1:0]  gap,
  input  logic              mode,
  output logic              ctrl,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [WCNT_W-1:0] win_cnt
);

  chan_state_e       state_q, state_d;
  mode_e             mode_q, mode_d;
  logic              en_d_q, en_d_d;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic              ctrl_q, ctrl_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [WCNT_W-1:0] win_q, win_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ONESHOT;
      en_d_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      gap_q   <= '0;
      ctrl_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      en_d_q  <= en_d_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      gap_q   <= gap_d;
      ctrl_q  <= ctrl_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    en_d_d  = en;
    // Starts are armed only once en has been seen low after reset, so an en
    // held high through reset cannot retrigger a window on release.
    armed_d = armed_q | ~en;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    gap_d   = gap_q;
    ctrl_d  = ctrl_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    win_d   = win_q;

    if (!en) begin
      state_d = ST_IDLE;
      ctrl_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!en_d_q && armed_q) begin
            tgt_d  = target;
            gap_d  = gap;
            mode_d = mode_e'(mode);
            win_d  = '0;
            if (target != '0) begin
              state_d = ST_RUN;
              cnt_d   = CNT_W'(1);
              ctrl_d  = 1'b1;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = '0;
              err_d   = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (cnt_q < tgt_q) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            ctrl_d = 1'b0;
            done_d = 1'b1;
            if (win_q != '1) win_d = win_q + 1'b1;
            // cnt is reused as the gap counter
            if (mode_q == MODE_PERIODIC) begin
              state_d = ST_GAP;
              cnt_d   = CNT_W'(1);
            end else begin
              state_d = ST_HOLD;
              cnt_d   = '0;
            end
          end
        end
        ST_GAP: begin
          if (cnt_q >= gap_q) begin
            state_d = ST_RUN;
            cnt_d   = CNT_W'(1);
            ctrl_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          ctrl_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          ctrl_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_GAP);
  end

  assign ctrl    = ctrl_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign win_cnt = win_q;

endmodule

// File: rtl/puf_window_timer.sv
// N_CH independent PUF excitation window timers on flattened per-channel buses.
module puf_window_timer
  import puf_timer_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned WCNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        en,
  input  logic [N_CH*CNT_W-1:0]  target,
  input  logic [N_CH*CNT_W-1:0]  gap,
  input  logic [N_CH-1:0]        mode,
  output logic [N_CH-1:0]        ctrl,
  output logic [N_CH-1:0]        done,
  output logic [N_CH-1:0]        err,
  output logic [N_CH-1:0]        busy,
  output logic [N_CH*WCNT_W-1:0] win_cnt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    puf_window_chan #(
      .CNT_W  (CNT_W),
      .WCNT_W (WCNT_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .target  (target[i*CNT_W +: CNT_W]),
      .gap     (gap[i*CNT_W +: CNT_W]),
      .mode    (mode[i]),
      .ctrl    (ctrl[i]),
      .done    (done[i]),
      .err     (err[i]),
      .busy    (busy[i]),
      .win_cnt (win_cnt[i*WCNT_W +: WCNT_W])
    );
  end

endmodule

// File: tb/tb_puf_window_timer.sv
// Scoreboard bench for puf_window_timer: a down-counting reference model queues
// the expected outputs per cycle, compared on the falling edge.
module tb_puf_window_timer;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned WW = 2;

  localparam int unsigned P_IDLE = 0;
  localparam int unsigned P_RUN  = 1;
  localparam int unsigned P_GAP  = 2;
  localparam int unsigned P_HOLD = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    en, mode;
  logic [N*CW-1:0] target, gap;
  logic [N-1:0]    ctrl, done, err, busy;
  logic [N*WW-1:0] win_cnt;

  typedef struct packed {
    logic [N-1:0]    ctrl;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic [N-1:0]    busy;
    logic [N*WW-1:0] win;
  } exp_t;

  exp_t sb[$];
  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  int unsigned m_phase[N], m_left[N], m_tgt[N], m_gap[N], m_win[N];
  logic        m_mode[N], m_en_d[N], m_armed[N], m_ctrl[N], m_done[N], m_err[N];
  int unsigned hi_cnt[N], err_cnt[N], done_cnt[N];

  puf_window_timer #(
    .N_CH   (N),
    .CNT_W  (CW),
    .WCNT_W (WW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .target  (target),
    .gap     (gap),
    .mode    (mode),
    .ctrl    (ctrl),
    .done    (done),
    .err     (err),
    .busy    (busy),
    .win_cnt (win_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      int unsigned t;
      t = int'(target[i*CW +: CW]);
      m_done[i] = 1'b0;
      m_err[i]  = 1'b0;
      if (rst) begin
        m_phase[i] = P_IDLE; m_left[i] = 0; m_tgt[i] = 0; m_gap[i] = 0;
        m_win[i] = 0; m_mode[i] = 1'b0; m_en_d[i] = 1'b0; m_armed[i] = 1'b0;
        m_ctrl[i] = 1'b0;
      end else begin
        if (!en[i]) begin
          m_phase[i] = P_IDLE;
          m_ctrl[i]  = 1'b0;
        end else begin
          case (m_phase[i])
            P_IDLE: if (!m_en_d[i] && m_armed[i]) begin
              m_tgt[i]  = t;
              m_gap[i]  = int'(gap[i*CW +: CW]);
              m_mode[i] = mode[i];
              m_win[i]  = 0;
              if (t == 0) begin
                m_phase[i] = P_HOLD;
                m_err[i]   = 1'b1;
              end else begin
                m_phase[i] = P_RUN;
                m_left[i]  = t - 1;
                m_ctrl[i]  = 1'b1;
              end
            end
            P_RUN: begin
              if (m_left[i] > 0) m_left[i]--;
              else begin
                m_ctrl[i] = 1'b0;
                m_done[i] = 1'b1;
                if (m_win[i] < (1 << WW) - 1) m_win[i]++;
                if (m_mode[i]) begin
                  m_phase[i] = P_GAP;
                  m_left[i]  = (m_gap[i] == 0) ? 0 : m_gap[i] - 1;
                end else begin
                  m_phase[i] = P_HOLD;
                end
              end
            end
            P_GAP: begin
              if (m_left[i] > 0) m_left[i]--;
              else begin
                m_phase[i] = P_RUN;
                m_ctrl[i]  = 1'b1;
                m_left[i]  = m_tgt[i] - 1;
              end
            end
            default: ;
          endcase
        end
        m_armed[i] = m_armed[i] | ~en[i];
        m_en_d[i]  = en[i];
      end
      e.ctrl[i] = m_ctrl[i];
      e.done[i] = m_done[i];
      e.err[i]  = m_err[i];
      e.busy[i] = (m_phase[i] == P_RUN) || (m_phase[i] == P_GAP);
      e.win[i*WW +: WW] = WW'(m_win[i]);
    end
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL sb_empty: got no expectation, want one");
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("ctrl[%0d]", i), 32'(ctrl[i]), 32'(e.ctrl[i]));
      chk($sformatf("done[%0d]", i), 32'(done[i]), 32'(e.done[i]));
      chk($sformatf("err[%0d]", i),  32'(err[i]),  32'(e.err[i]));
      chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(e.busy[i]));
      chk($sformatf("win[%0d]", i),  32'(win_cnt[i*WW +: WW]), 32'(e.win[i*WW +: WW]));
      if (ctrl[i] === 1'b1) hi_cnt[i]++;
      if (err[i] === 1'b1)  err_cnt[i]++;
      if (done[i] === 1'b1) done_cnt[i]++;
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
    end
  endtask

  task automatic cfg(input int unsigned ch, input int unsigned t, input int unsigned g,
                     input logic md);
    target[ch*CW +: CW] = CW'(t);
    gap[ch*CW +: CW]    = CW'(g);
    mode[ch]            = md;
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      hi_cnt[i] = 0; err_cnt[i] = 0; done_cnt[i] = 0;
    end
  endtask

  initial begin
    rst = 1'b1; en = '0; mode = '0; target = '0; gap = '0;
    clr();
    step(2);
    rst = 1'b0;
    step(3);

    // One-shot 50-cycle window on channel 0.
    cfg(0, 50, 0, 1'b0); clr();
    en[0] = 1'b1;
    step(56);
    chk("oneshot_hi_cycles", hi_cnt[0], 50);
    chk("oneshot_done_cnt", done_cnt[0], 1);
    chk("oneshot_win", 32'(win_cnt[0 +: WW]), 1);
    chk("oneshot_busy_after", 32'(busy[0]), 0);
    en[0] = 1'b0;
    step(2);

    // Periodic 3 on / 2 off for 20 cycles; four windows saturate a 2-bit tally.
    cfg(1, 3, 2, 1'b1); clr();
    en[1] = 1'b1;
    step(20);
    chk("periodic_hi_cycles", hi_cnt[1], 12);
    chk("periodic_done_cnt", done_cnt[1], 4);
    chk("periodic_win_sat", 32'(win_cnt[WW +: WW]), 3);
    en[1] = 1'b0;
    step(2);

    // Zero target: a single err pulse and no window.
    cfg(2, 0, 0, 1'b0); clr();
    en[2] = 1'b1;
    step(5);
    chk("zero_err_cnt", err_cnt[2], 1);
    chk("zero_hi_cycles", hi_cnt[2], 0);
    chk("zero_done_cnt", done_cnt[2], 0);
    en[2] = 1'b0;
    step(2);

    // Zero gap in periodic mode: 2 on / 1 off.
    cfg(3, 2, 0, 1'b1); clr();
    en[3] = 1'b1;
    step(12);
    chk("gap0_hi_cycles", hi_cnt[3], 8);
    en[3] = 1'b0;
    step(2);

    // Window cut short by en, then a full window after en returns.
    cfg(0, 50, 0, 1'b0); clr();
    en[0] = 1'b1;
    step(10);
    en[0] = 1'b0;
    step(3);
    chk("abort_done_cnt", done_cnt[0], 0);
    chk("abort_win", 32'(win_cnt[0 +: WW]), 0);
    clr();
    en[0] = 1'b1;
    step(55);
    chk("rearm_hi_cycles", hi_cnt[0], 50);
    chk("rearm_win", 32'(win_cnt[0 +: WW]), 1);
    en[0] = 1'b0;
    step(2);

    // Reset mid-window drops ctrl at once; no restart until en toggles.
    en[0] = 1'b1;
    step(10);
    rst = 1'b1;
    #1;
    chk("rst_async_ctrl", 32'(ctrl[0]), 0);
    chk("rst_async_busy", 32'(busy[0]), 0);
    step(2);
    rst = 1'b0; clr();
    step(5);
    chk("rst_no_restart", hi_cnt[0], 0);
    en[0] = 1'b0;
    step(2);
    en[0] = 1'b1;
    step(52);
    chk("rst_retoggle_hi", hi_cnt[0], 50);
    en[0] = 1'b0;
    step(2);

    // Staggered starts; a post-start target change on ch0 must be ignored.
    clr();
    cfg(0, 7, 0, 1'b0); en[0] = 1'b1;
    step(1);
    cfg(0, 1, 0, 1'b0);
    cfg(1, 5, 3, 1'b1); en[1] = 1'b1;
    step(2);
    cfg(2, 9, 1, 1'b1); en[2] = 1'b1;
    step(1);
    cfg(3, 4, 0, 1'b0); en[3] = 1'b1;
    step(40);
    chk("stagger_ch0_hi", hi_cnt[0], 7);
    chk("stagger_ch3_hi", hi_cnt[3], 4);
    chk("stagger_ch1_win", 32'(win_cnt[WW +: WW]), 3);
    en = '0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
